// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller for the rv32is load/store port.
// Owns a word-wide single-port RAM. Loads return sign/zero-extended byte,
// halfword or word data. Sub-word stores do a read-modify-write.
//
// Ports:
//   clock  - single clock, all state on posedge
//   reset  - synchronous active-low reset (RAM contents preserved)
//   req    - access request, sampled only while busy=0
//   we     - 1 = store, 0 = load
//   addr   - byte address
//   wdata  - store data (low byte/halfword for SB/SH)
//   op     - 000 B, 001 H, 010 W, 100 BU, 101 HU
//   rdata  - extended load result, held until the next load completes
//   busy   - high whenever the FSM is not idle
//   done   - one-cycle completion pulse
//   err    - one-cycle error flag, only with done
module dmem_ctrl #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  op,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e state_q, state_d;

  logic [31:0] mem [Depth];

  // Access context latched at acceptance.
  logic                  we_q;
  logic [2:0]            op_q;
  logic [1:0]            lane_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic [31:0]           word_q;

  logic        bad_op, misaligned, out_of_range, req_err, accept;
  logic        mem_we, done_d, err_d;
  logic [31:0] rdata_d, merged, load_val;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign busy = (state_q != StIdle);

  always_comb begin
    bad_op       = (op == 3'b011) || (op[2:1] == 2'b11) || (we && op[2]);
    misaligned   = ((op[1:0] == 2'b01) && addr[0]) ||
                   ((op[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    out_of_range = (addr >> (DEPTH_LOG2 + 2)) != 32'd0;
    req_err      = bad_op || misaligned || out_of_range;
    accept       = (state_q == StIdle) && req;
  end

  // Lane extraction from the registered RAM word.
  always_comb begin
    sel_byte = word_q[7:0];
    unique case (lane_q)
      2'd0: sel_byte = word_q[7:0];
      2'd1: sel_byte = word_q[15:8];
      2'd2: sel_byte = word_q[23:16];
      2'd3: sel_byte = word_q[31:24];
      default: sel_byte = word_q[7:0];
    endcase
    sel_half = lane_q[1] ? word_q[31:16] : word_q[15:0];
    unique case (op_q)
      3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_val = {24'd0, sel_byte};
      3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
      3'b101:  load_val = {16'd0, sel_half};
      default: load_val = word_q;
    endcase
  end

  // Store merge: full word for SW, otherwise patch the addressed lane.
  always_comb begin
    merged = word_q;
    if (op_q[1:0] == 2'b00) begin
      unique case (lane_q)
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = word_q;
      endcase
    end else if (op_q[1:0] == 2'b01) begin
      if (lane_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end else begin
      merged = wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (req_err) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (we && (op == 3'b010)) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd:   state_d = we_q ? StWr : StResp;
      StWr: begin
        mem_we  = 1'b1;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StResp: begin
        rdata_d = load_val;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      rdata   <= 32'd0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata   <= rdata_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

  // Datapath and RAM carry no reset; a reset in WR must still block the write.
  always_ff @(posedge clock) begin
    if (accept) begin
      we_q    <= we;
      op_q    <= op;
      lane_q  <= addr[1:0];
      idx_q   <= addr[DEPTH_LOG2+1:2];
      wdata_q <= wdata;
    end
    if (state_q == StRd) word_q <= mem[idx_q];
    if (reset && mem_we) mem[idx_q] <= merged;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  logic        clock, reset, req, we;
  logic [31:0] addr, wdata, rdata;
  logic [2:0]  op;
  logic        busy, done, err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    int          lat;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];

  dmem_ctrl #(.DEPTH_LOG2(10), .INIT_FILE("")) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .op(op), .rdata(rdata), .busy(busy), .done(done), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one access, queue its expectation, then wait for done and compare.
  task automatic access(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] o, input int lat,
                        input logic e, input logic [31:0] rd);
    exp_t x;
    int   n;
    @(negedge clock);
    req = 1'b1; we = w; addr = a; wdata = d; op = o;
    x.tag = tag; x.lat = lat; x.err = e; x.rd = rd;
    sb.push_back(x);
    @(posedge clock); #1;
    req = 1'b0;
    n = 0;
    while (!done && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    x = sb.pop_front();
    check({x.tag, ".lat"}, n, x.lat);
    check({x.tag, ".err"}, {31'd0, err}, {31'd0, x.err});
    check({x.tag, ".rdata"}, rdata, x.rd);
    check({x.tag, ".busy"}, {31'd0, busy}, 32'd0);
    @(posedge clock); #1;
    check({x.tag, ".done_clr"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int ndone;
    reset = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h10; wdata = 32'd0; op = 3'b010;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      check("rst.busy", {31'd0, busy}, 32'd0);
      check("rst.done", {31'd0, done}, 32'd0);
      check("rst.err", {31'd0, err}, 32'd0);
      check("rst.rdata", rdata, 32'd0);
    end
    @(negedge clock);
    reset = 1'b1; req = 1'b0;

    access("sw",   1'b1, 32'h10, 32'h12345678, 3'b010, 1, 1'b0, 32'h0);
    access("lw0",  1'b0, 32'h10, 32'h0,        3'b010, 2, 1'b0, 32'h12345678);
    access("sb",   1'b1, 32'h11, 32'hFFFFFF9A, 3'b000, 2, 1'b0, 32'h12345678);
    access("lw1",  1'b0, 32'h10, 32'h0,        3'b010, 2, 1'b0, 32'h12349A78);
    access("lb",   1'b0, 32'h11, 32'h0,        3'b000, 2, 1'b0, 32'hFFFFFF9A);
    access("lbu",  1'b0, 32'h11, 32'h0,        3'b100, 2, 1'b0, 32'h0000009A);
    access("lb0",  1'b0, 32'h10, 32'h0,        3'b000, 2, 1'b0, 32'h00000078);
    access("sh",   1'b1, 32'h12, 32'h0000BEEF, 3'b001, 2, 1'b0, 32'h00000078);
    access("lw2",  1'b0, 32'h10, 32'h0,        3'b010, 2, 1'b0, 32'hBEEF9A78);
    access("lh",   1'b0, 32'h12, 32'h0,        3'b001, 2, 1'b0, 32'hFFFFBEEF);
    access("lhu",  1'b0, 32'h12, 32'h0,        3'b101, 2, 1'b0, 32'h0000BEEF);

    access("e_lw_mis", 1'b0, 32'h13,   32'h0,  3'b010, 0, 1'b1, 32'h0000BEEF);
    access("lw3",      1'b0, 32'h10,   32'h0,  3'b010, 2, 1'b0, 32'hBEEF9A78);
    access("e_sh_mis", 1'b1, 32'h11,   32'hAA, 3'b001, 0, 1'b1, 32'hBEEF9A78);
    access("lw4",      1'b0, 32'h10,   32'h0,  3'b010, 2, 1'b0, 32'hBEEF9A78);
    access("e_op011",  1'b0, 32'h10,   32'h0,  3'b011, 0, 1'b1, 32'hBEEF9A78);
    access("lw5",      1'b0, 32'h10,   32'h0,  3'b010, 2, 1'b0, 32'hBEEF9A78);
    access("e_sbu",    1'b1, 32'h10,   32'hFF, 3'b100, 0, 1'b1, 32'hBEEF9A78);
    access("lw6",      1'b0, 32'h10,   32'h0,  3'b010, 2, 1'b0, 32'hBEEF9A78);
    access("e_range",  1'b0, 32'h1000, 32'h0,  3'b010, 0, 1'b1, 32'hBEEF9A78);
    access("lw7",      1'b0, 32'h10,   32'h0,  3'b010, 2, 1'b0, 32'hBEEF9A78);

    // req held high while an SB is in RD must be ignored.
    @(negedge clock);
    req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h55; op = 3'b000;
    @(posedge clock); #1;
    check("ign.busy", {31'd0, busy}, 32'd1);
    we = 1'b0; op = 3'b010;
    @(posedge clock); #1;
    req = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      @(posedge clock); #1;
    end
    check("ign.ndone", ndone, 1);
    access("lw8", 1'b0, 32'h10, 32'h0, 3'b010, 2, 1'b0, 32'hBEEF9A55);

    // Reset landing in WR must drop the write and the done.
    @(negedge clock);
    req = 1'b1; we = 1'b1; addr = 32'h13; wdata = 32'h11; op = 3'b000;
    @(posedge clock); #1;
    req = 1'b0;
    @(posedge clock); #1;
    check("rwr.busy_wr", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    @(posedge clock); #1;
    check("rwr.done", {31'd0, done}, 32'd0);
    check("rwr.busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (done) ndone++;
    end
    check("rwr.ndone", ndone, 0);
    check("rwr.idle", {31'd0, busy}, 32'd0);
    access("lw9", 1'b0, 32'h10, 32'h0, 3'b010, 2, 1'b0, 32'hBEEF9A55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
